// File: rtl/preg_wb_arbiter_pkg.sv
// Shared backend constants for the physical-register writeback arbiter.
// Register geometry matches the regfile's PREG_RANGE/PREG_LENGTH.
package preg_wb_arbiter_pkg;
  localparam int PREG_LENGTH = 6;
  localparam int PREG_RANGE  = 1 << PREG_LENGTH;
  localparam int DATA_LENGTH = 64;
  localparam int CNT_W       = 32;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/preg_wb_arbiter_wb_rr_pick2.sv
// Round-robin pick of up to two eligible entries; the second grant
// never targets the same preg as the first.
module wb_rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = 6,
  parameter int IW = 2
) (
  input  logic [N-1:0]    elig_i,
  input  logic [IW-1:0]   rr_ptr_i,
  input  logic [N*PW-1:0] pdst_i,
  output logic [N-1:0]    gnt0_o,
  output logic [N-1:0]    gnt1_o,
  output logic            vld0_o,
  output logic            vld1_o
);
  logic [IW:0]   s;
  logic [IW-1:0] idx;
  logic [PW-1:0] p0;

  always_comb begin
    gnt0_o = '0;
    gnt1_o = '0;
    vld0_o = 1'b0;
    vld1_o = 1'b0;
    p0     = '0;
    s      = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, rr_ptr_i} + (IW+1)'(k);
      if (s >= (IW+1)'(N))
        s = s - (IW+1)'(N);
      idx = s[IW-1:0];
      if (elig_i[idx]) begin
        if (!vld0_o) begin
          vld0_o      = 1'b1;
          gnt0_o[idx] = 1'b1;
          p0          = pdst_i[idx*PW +: PW];
        end else if (!vld1_o &&
                     pdst_i[idx*PW +: PW] != p0) begin
          vld1_o      = 1'b1;
          gnt1_o[idx] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/preg_wb_arbiter.sv
// Buffers one result per writeback requester and drains up to two
// per cycle onto the regfile write ports, round-robin.
module preg_wb_arbiter
  import preg_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PREG_W  = PREG_LENGTH,
  parameter int DATA_W  = DATA_LENGTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*PREG_W-1:0] req_pdst,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      wren0,
  output logic [PREG_W-1:0]         waddr0,
  output logic [DATA_W-1:0]         wdata0,
  output logic                      wren1,
  output logic [PREG_W-1:0]         waddr1,
  output logic [DATA_W-1:0]         wdata1,
  output logic [31:0]               conflict_cnt
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        hv_q, hv_d;
  logic [NUM_REQ*PREG_W-1:0] hpdst_q, hpdst_d;
  logic [NUM_REQ*DATA_W-1:0] hdata_q, hdata_d;
  logic [IW-1:0]             rr_q, rr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [NUM_REQ-1:0] elig, drop, gnt0, gnt1, rel, acc;
  logic               vld0, vld1;
  logic [IW:0]        nelig;
  logic [IW-1:0]      idx0, idx1;

  always_comb begin
    elig = '0;
    drop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = hv_q[i] && (hpdst_q[i*PREG_W +: PREG_W] != '0);
      drop[i] = hv_q[i] && (hpdst_q[i*PREG_W +: PREG_W] == '0);
    end
  end

  wb_rr_pick2 #(
    .N  (NUM_REQ),
    .PW (PREG_W),
    .IW (IW)
  ) u_pick (
    .elig_i   (elig),
    .rr_ptr_i (rr_q),
    .pdst_i   (hpdst_q),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .vld0_o   (vld0),
    .vld1_o   (vld1)
  );

  always_comb begin
    rel       = flush ? '0 : (gnt0 | gnt1 | drop);
    req_ready = flush ? '0 : (~hv_q | rel);
    acc       = req_valid & req_ready;
    wren0     = vld0 && !flush;
    wren1     = vld1 && !flush;
    waddr0    = '0;
    wdata0    = '0;
    waddr1    = '0;
    wdata1    = '0;
    idx0      = '0;
    idx1      = '0;
    nelig     = '0;
    hpdst_d   = hpdst_q;
    hdata_d   = hdata_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt0[i] && !flush) begin
        waddr0 = hpdst_q[i*PREG_W +: PREG_W];
        wdata0 = hdata_q[i*DATA_W +: DATA_W];
        idx0   = IW'(i);
      end
      if (gnt1[i] && !flush) begin
        waddr1 = hpdst_q[i*PREG_W +: PREG_W];
        wdata1 = hdata_q[i*DATA_W +: DATA_W];
        idx1   = IW'(i);
      end
      if (acc[i]) begin
        hpdst_d[i*PREG_W +: PREG_W] = req_pdst[i*PREG_W +: PREG_W];
        hdata_d[i*DATA_W +: DATA_W] = req_data[i*DATA_W +: DATA_W];
      end
      nelig = nelig + (IW+1)'(elig[i]);
    end
    // Pointer moves past the highest-priority-order grant of the cycle
    rr_d = rr_q;
    if (wren1)
      rr_d = (idx1 == IW'(NUM_REQ-1)) ? '0 : idx1 + 1'b1;
    else if (wren0)
      rr_d = (idx0 == IW'(NUM_REQ-1)) ? '0 : idx0 + 1'b1;
    cnt_d = (!flush && nelig > (IW+1)'(2)) ? sat_inc(cnt_q) : cnt_q;
    hv_d  = flush ? '0 : ((hv_q & ~rel) | acc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hv_q    <= '0;
      hpdst_q <= '0;
      hdata_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      hv_q    <= hv_d;
      hpdst_q <= hpdst_d;
      hdata_q <= hdata_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
endmodule

// File: doc/preg_wb_arbiter.md
PREG_WB_ARBITER -- requirements
Module: preg_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of writeback requesters (2..8).
REQ-002 SHALL have parameter PREG_W, default 6, meaning physical register index width.
REQ-003 SHALL have parameter DATA_W, default 64, meaning result data width.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1, pipeline flush: kill all buffered results.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester result valid.
REQ-008 SHALL have port req_ready, output, NUM_REQ, per-requester result accepted.
REQ-009 SHALL have port req_pdst, input, NUM_REQ*PREG_W, destination preg per requester (packed, requester i at [i*PREG_W +: PREG_W]).
REQ-010 SHALL have port req_data, input, NUM_REQ*DATA_W, result data per requester (packed likewise).
REQ-011 SHALL have ports wren0/waddr0/wdata0 and wren1/waddr1/wdata1, output, 1/PREG_W/DATA_W each, driving regfile write ports 0 and 1.
REQ-012 SHALL have port conflict_cnt, output, 32, count of cycles with more than 2 eligible pending entries.

Function
REQ-013 SHALL hold one buffer entry per requester: hv[i], hpdst[i], hdata[i].
REQ-014 SHALL drive req_ready[i] = !flush && (!hv[i] || grant[i]); depends on registered state and flush only, never on req_valid.
REQ-015 SHALL accept requester i when req_valid[i] && req_ready[i]: load hpdst/hdata, set hv[i] next cycle.
REQ-016 SHALL write an accepted result to the regfile no earlier than 1 cycle after acceptance; one-per-cycle sustained throughput per requester when granted every cycle.
REQ-017 SHALL treat entry i as eligible when hv[i] && hpdst[i] != 0.
REQ-018 SHALL clear entries with hv[i] && hpdst[i] == 0 in one cycle without consuming a write port (p0 writes discarded).
REQ-019 SHALL grant at most 2 eligible entries per cycle by round-robin search starting at rr_ptr, ascending with wrap at NUM_REQ.
REQ-020 SHALL map first grant to port 0, second grant to port 1; unused ports drive wren=0, waddr=0, wdata=0.
REQ-021 SHALL skip as second grant any entry whose hpdst equals the first grant's hpdst; the skipped entry stays buffered.
REQ-022 SHALL clear hv[i] when granted, unless a new request is accepted the same cycle (then entry is reloaded, hv stays 1).
REQ-023 SHALL update rr_ptr to (last granted index + 1) mod NUM_REQ; rr_ptr unchanged when no grant.
REQ-024 SHALL, on flush, clear all hv, suppress all grants and wren that cycle, and accept nothing; rr_ptr unchanged.
REQ-025 SHALL increment conflict_cnt (saturating at 2^32-1) each non-flush cycle with more than 2 eligible entries.
REQ-026 SHALL guarantee no requester starves: every eligible entry granted within ceil(NUM_REQ/2)+1 cycles absent flush.

Reset
REQ-027 SHALL on reset_n low asynchronously clear hv to 0, rr_ptr to 0, conflict_cnt to 0, hpdst/hdata to 0.
REQ-028 SHALL drive during and after reset: wren0=wren1=0, waddr*=0, wdata*=0, req_ready all 1 (when flush=0).
REQ-029 SHALL, on reset asserted mid-operation, discard all buffered results with no partial write.

Structure
REQ-030 SHALL take PREG_W/DATA_W defaults and the preg range from the shared backend defines/package (same as regfile PREG_RANGE/PREG_LENGTH).
REQ-031 SHALL implement grant selection in one combinational sub-module wb_rr_pick2 (inputs eligible mask, rr_ptr, pdst vector; outputs two one-hot grants + valid bits).

Verification
REQ-032 SHALL test: reset, then req0 pdst=5 data=0xAA -> next cycle wren0=1 waddr0=5 wdata0=0xAA, wren1=0.
REQ-033 SHALL test: req0..3 valid same cycle pdst=1,2,3,4, rr_ptr=0 -> cycle+1 ports write 1,2; cycle+2 write 3,4; conflict_cnt=1.
REQ-034 SHALL test: req1 pdst=0 data=0xFF -> entry dropped next cycle, wren0=wren1=0, req_ready[1]=1.
REQ-035 SHALL test: req0 and req2 both pdst=7 buffered -> only one write to 7 per cycle, other on following cycle.
REQ-036 SHALL test: entries buffered then flush=1 -> same cycle wren=0, req_ready=0; next cycle hv all 0, no writes.
REQ-037 SHALL test: req3 held valid continuously with all others busy -> req3 written within 3 cycles (NUM_REQ=4).
